data_memory: RTL and testbench

- Word-organised data RAM for the 32-bit processor's MEM stage.
- Synchronous write on the rising clock edge; combinational read gated by MemRead.
- Byte address from the ALU maps to a word index; low two bits ignored.
- Synchronous active-low reset clears the whole array.

---
 rtl/data_memory_pkg.sv | 12 +
 rtl/data_memory_word_array.sv | 30 +++
 rtl/data_memory.sv | 35 +++
 tb/tb_data_memory.sv | 145 ++++++++++++++
 4 files changed

// File: rtl/data_memory_pkg.sv
// Shared constants for the MEM-stage data RAM: word/address geometry and
// the all-zero word used for clear and read gating.
package data_memory_pkg;

  localparam int DATA_WIDTH = 32;
  localparam int ADDR_WIDTH = 32;
  localparam int DEPTH      = 1024;
  localparam int IDX_BITS   = $clog2(DEPTH);

  localparam logic [DATA_WIDTH-1:0] ZERO_WORD = '0;

endpackage

// File: rtl/data_memory_word_array.sv
// Word storage for the data RAM: synchronous bulk clear, single write port
// and one asynchronous read port addressed by word index.
module data_memory_word_array
  import data_memory_pkg::*;
(
  input  logic                  Clk,
  input  logic                  Rst_n,
  input  logic                  we,
  input  logic [IDX_BITS-1:0]   widx,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic [IDX_BITS-1:0]   ridx,
  output logic [DATA_WIDTH-1:0] rdata
);

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  // Reset wins over a concurrent write; X on we falls through as no-write.
  always_ff @(posedge Clk) begin
    if (!Rst_n) begin
      mem <= '{default: ZERO_WORD};
    end else if (we) begin
      mem[widx] <= wdata;
    end
  end

  // Read is taken straight from the array, so a same-index write only
  // becomes visible after the edge.
  assign rdata = mem[ridx];

endmodule

// File: rtl/data_memory.sv
// MEM-stage data RAM: byte address to word index, synchronous write,
// combinational read forced to zero when MemRead is low.
module data_memory
  import data_memory_pkg::*;
(
  input  logic                  Clk,
  input  logic                  Rst_n,
  input  logic [ADDR_WIDTH-1:0] Address,
  input  logic [DATA_WIDTH-1:0] WriteData,
  input  logic                  MemWrite,
  input  logic                  MemRead,
  output logic [DATA_WIDTH-1:0] ReadData
);

  logic [IDX_BITS-1:0]   idx;
  logic [DATA_WIDTH-1:0] word;
  logic                  unused_addr;

  // Byte offset and bits above the array span do not select a word.
  assign idx         = Address[IDX_BITS+1:2];
  assign unused_addr = ^{Address[ADDR_WIDTH-1:IDX_BITS+2], Address[1:0]};

  data_memory_word_array u_array (
    .Clk   (Clk),
    .Rst_n (Rst_n),
    .we    (MemWrite),
    .widx  (idx),
    .wdata (WriteData),
    .ridx  (idx),
    .rdata (word)
  );

  assign ReadData = MemRead ? word : ZERO_WORD;

endmodule

// File: tb/tb_data_memory.sv
// Bench for data_memory: directed checks of reset, gating, alignment and
// wrap, then randomized traffic compared against an array reference.
module tb_data_memory;
  import data_memory_pkg::*;

  logic                  Clk = 1'b0;
  logic                  Rst_n;
  logic [ADDR_WIDTH-1:0] Address;
  logic [DATA_WIDTH-1:0] WriteData;
  logic                  MemWrite;
  logic                  MemRead;
  logic [DATA_WIDTH-1:0] ReadData;

  int total = 0;
  int bad   = 0;

  logic [DATA_WIDTH-1:0] ref_mem [DEPTH];

  data_memory dut (
    .Clk       (Clk),
    .Rst_n     (Rst_n),
    .Address   (Address),
    .WriteData (WriteData),
    .MemWrite  (MemWrite),
    .MemRead   (MemRead),
    .ReadData  (ReadData)
  );

  always #5 Clk = ~Clk;

  task automatic chk(input string tag, input logic [DATA_WIDTH-1:0] got,
                     input logic [DATA_WIDTH-1:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  // Byte address to word slot: drop the byte offset, wrap modulo the array.
  function automatic int word_of(input logic [ADDR_WIDTH-1:0] a);
    return int'((a / 4) % DEPTH);
  endfunction

  function automatic logic [DATA_WIDTH-1:0] model_read();
    return MemRead ? ref_mem[word_of(Address)] : '0;
  endfunction

  // One rising edge; the reference applies whatever the inputs requested.
  task automatic tick();
    logic                  r, w;
    logic [ADDR_WIDTH-1:0] a;
    logic [DATA_WIDTH-1:0] d;
    r = Rst_n; w = MemWrite; a = Address; d = WriteData;
    @(posedge Clk);
    if (!r) begin
      for (int i = 0; i < DEPTH; i++) ref_mem[i] = '0;
    end else if (w) begin
      ref_mem[word_of(a)] = d;
    end
    #1;
  endtask

  task automatic rd(input logic [ADDR_WIDTH-1:0] a, input string tag,
                    input logic [DATA_WIDTH-1:0] exp);
    Address = a;
    #1;
    chk(tag, ReadData, exp);
  endtask

  task automatic wr(input logic [ADDR_WIDTH-1:0] a, input logic [DATA_WIDTH-1:0] d);
    Address = a; WriteData = d; MemWrite = 1'b1;
    tick();
    MemWrite = 1'b0;
  endtask

  initial begin
    Rst_n = 1'b0; MemWrite = 1'b0; MemRead = 1'b0;
    Address = '0; WriteData = '0;
    for (int i = 0; i < DEPTH; i++) ref_mem[i] = '0;
    #2;
    tick();
    tick();
    Rst_n = 1'b1;

    MemRead = 1'b1;
    rd(32'h0,   "rst_rd0",   32'h0);
    rd(32'h4,   "rst_rd4",   32'h0);
    rd(32'hFFC, "rst_rdffc", 32'h0);

    MemRead = 1'b0;
    wr(32'h0, 32'h12345678);
    wr(32'h4, 32'hABCDEF98);
    wr(32'h8, 32'hFFFFFFFF);
    MemRead = 1'b1;
    rd(32'h0, "wr_rd0", 32'h12345678);
    rd(32'h4, "wr_rd4", 32'hABCDEF98);
    rd(32'h8, "wr_rd8", 32'hFFFFFFFF);

    MemRead = 1'b0;
    rd(32'h4, "gate_off", 32'h0);
    MemRead = 1'b1;
    #1;
    chk("gate_on", ReadData, 32'hABCDEF98);

    rd(32'h6, "unaligned", 32'hABCDEF98);
    wr(32'h1000, 32'hCAFEBABE);
    rd(32'h0,    "wrap_rd0",    32'hCAFEBABE);
    rd(32'h1004, "wrap_alias4", 32'hABCDEF98);

    Address = 32'h8; WriteData = 32'h00000055; MemWrite = 1'b1;
    #1;
    chk("rw_before", ReadData, 32'hFFFFFFFF);
    tick();
    chk("rw_after", ReadData, 32'h00000055);
    MemWrite = 1'b0;

    rd(32'hFFC, "untouched", 32'h0);

    Rst_n = 1'b0; MemWrite = 1'b1; WriteData = 32'h11111111; Address = 32'h10;
    tick();
    Rst_n = 1'b1; MemWrite = 1'b0;
    rd(32'h10, "rst_mid10", 32'h0);
    rd(32'h0,  "rst_mid0",  32'h0);
    rd(32'h8,  "rst_mid8",  32'h0);

    // Random traffic: addresses concentrated on a small window so reads hit
    // recent writes, with occasional full-range addresses and resets.
    for (int n = 0; n < 600; n++) begin
      Rst_n     = ($urandom_range(0, 63) != 0);
      MemWrite  = $urandom_range(0, 1);
      MemRead   = ($urandom_range(0, 3) != 0);
      WriteData = $urandom;
      Address   = ($urandom_range(0, 3) == 0) ? $urandom : $urandom_range(0, 255);
      #1;
      chk("rnd_pre", ReadData, model_read());
      tick();
      chk("rnd_post", ReadData, model_read());
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
